cpu_state_dumper: RTL and testbench
===================================

Name: cpu_state_dumper

Overview:
- Hardware counterpart to the bench's end-of-run state printout.
- Counts retired instructions of the single-cycle CPU and freezes the CPU at a programmed count or on request.
- Then reads out all 32 registers, followed by a window of data-memory words, as a valid/ready word stream for a host or trace sink.
- Sits beside CPU: it drives the CPU halt input and owns a spare read port on regFile and dataMem.

Parameters:
- INST_NUM, 35, retire count that triggers the dump; 0 disables the count trigger (dump_req only).
- DM_BASE_WORD, 20, first data-memory word index dumped (byte address 80).
- DM_WORDS, 2, number of data-memory words dumped; range 1..64.
- DM_AW, 10, data-memory word-address width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low.
- retire  input  1  one instruction retired this cycle (1 every cycle for the single-cycle CPU).
- dump_req  input  1  one-cycle pulse requesting an immediate dump.
- cpu_halt  output  1  freezes PC and all CPU state writes while high.
- rf_raddr  output  5  register-file spare read address.
- rf_rdata  input  32  combinational read data for rf_raddr.
- dm_raddr  output  DM_AW  data-memory spare read word address.
- dm_rdata  input  32  combinational read data for dm_raddr.
- dump_valid  output  1  dump_data/dump_tag/dump_last valid.
- dump_ready  input  1  sink accepts the word.
- dump_data  output  32  dumped word.
- dump_tag  output  8  bit7=0: register, bits4:0 = register number; bit7=1: memory, bits5:0 = offset from DM_BASE_WORD.
- dump_last  output  1  marks the final word of the dump.
- done  output  1  dump complete; stays high until reset.

Behaviour:
- Reset (rst low, asynchronous): state RUN. cpu_halt=0, dump_valid=0, dump_data=0, dump_tag=0, dump_last=0, done=0, retire counter=0, index=0, rf_raddr=0, dm_raddr=DM_BASE_WORD.
- Reset asserted mid-dump aborts the dump immediately. Halt releases and no partial word remains valid.
- States:
  - RUN: counter increments on retire.
  - REGS: index 0..31.
  - MEM: index 0..DM_WORDS-1.
  - DONE.
- RUN -> REGS on either trigger below; cpu_halt is registered high on that same edge.
  - retire with counter==INST_NUM-1 (INST_NUM!=0). The INST_NUM-th retire is the last one the CPU performs.
  - dump_req.
- If both triggers occur in the same cycle, exactly one dump results. dump_req outside RUN is ignored.
- cpu_halt stays high in REGS, MEM and DONE. retire is ignored whenever cpu_halt=1.
- Read addresses: rf_raddr=index in REGS; dm_raddr=DM_BASE_WORD+index in MEM (DM_AW-bit add, wraps modulo 2^DM_AW).
- Output register load condition: state is REGS/MEM and (dump_valid=0 or dump_ready=1). On load:
  - dump_data = read data; register 0 is always reported as 0.
  - tag set as described above.
  - dump_last = (MEM and index==DM_WORDS-1).
  - dump_valid=1, then index advances.
- Throughput is one word per cycle while dump_ready is held high. The first word is valid 1 cycle after entering REGS.
- Stall: while dump_valid=1 and dump_ready=0, dump_data, dump_tag and dump_last hold stable. A valid word is never dropped or duplicated.
- After loading index 31 in REGS: index=0, go to MEM.
- After loading the last MEM word: go to DONE. dump_valid clears when that word is accepted. done=1 on the acceptance edge.
- Exactly 32+DM_WORDS handshakes per dump.
- Counter is 32 bits and saturates; it never wraps in RUN.

Decomposition:
- Shared package cpu_dbg_pkg holds:
  - state encoding constants ST_RUN, ST_REGS, ST_MEM, ST_DONE;
  - tag field constants TAG_MEM_BIT=7, TAG_IDX_W;
  - REG_COUNT=32.
- One natural sub-module: dump_out_reg, a single-entry valid/ready output register with load and hold logic. The FSM and counter stay in the top module.

Test Plan:
- INST_NUM=35, retire=1 every cycle, dump_ready=1 → cpu_halt rises on the edge of the 35th retire. 34 words follow in consecutive cycles. Tags 0x00..0x1F then 0x80, 0x81. dump_last only on tag 0x81. done=1 after the 34th handshake. With dmem[20]=5, the tag-0x80 word = 5.
- Regfile preloaded with rf[0]=0xDEADBEEF and rf[31]=0x12345678 → tag 0x00 word = 0; tag 0x1F word = 0x12345678.
- dump_ready toggled 1,0,0,1 repeatedly → each word is held stable across stalls. The received sequence exactly matches the no-stall run (34 words, no gaps or repeats).
- dump_req pulsed at cycle 10 with INST_NUM=35 → dump starts with counter=10. A later retire pulse or dump_req changes nothing. Only one dump occurs.
- dump_req in the same cycle as the 35th retire → a single 34-word dump.
- rst driven low after the 12th word is accepted → all outputs return to reset values asynchronously, cpu_halt=0. After release, the counter restarts from 0 and a full dump recurs after 35 more retires.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU state dumper: FSM state codes, dump tag layout
// and tag-building helpers.
package cpu_dbg_pkg;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_REGS = 2'd1;
    localparam logic [1:0] ST_MEM  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int TAG_MEM_BIT = 7;
    localparam int TAG_IDX_W   = 6;
    localparam int REG_COUNT   = 32;
    localparam int WORD_W      = 32;
    localparam int TAG_W       = 8;

    function automatic logic [TAG_W-1:0] reg_tag(input logic [4:0] reg_num);
        logic [TAG_W-1:0] t;
        t      = '0;
        t[4:0] = reg_num;
        return t;
    endfunction

    // Memory words carry their offset from the dump window base, not the absolute address.
    function automatic logic [TAG_W-1:0] mem_tag(input logic [TAG_IDX_W-1:0] offset);
        logic [TAG_W-1:0] t;
        t                 = '0;
        t[TAG_IDX_W-1:0]  = offset;
        t[TAG_MEM_BIT]    = 1'b1;
        return t;
    endfunction

endpackage

// File: rtl/dump_out_reg.sv
// Single-entry valid/ready output register: loads a new word when empty or when
// the current word is being accepted, otherwise holds it stable.
module dump_out_reg
    import cpu_dbg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              ready,
    input  logic [WORD_W-1:0] load_data,
    input  logic [TAG_W-1:0]  load_tag,
    input  logic              load_last,
    output logic              valid,
    output logic [WORD_W-1:0] data,
    output logic [TAG_W-1:0]  tag,
    output logic              last
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
            tag   <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            tag   <= load_tag;
            last  <= load_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_state_dumper.sv
// Freezes the CPU after a programmed retire count or on request, then streams the
// register file and a data-memory window out as tagged valid/ready words.
module cpu_state_dumper
    import cpu_dbg_pkg::*;
#(
    parameter int INST_NUM     = 35,
    parameter int DM_BASE_WORD = 20,
    parameter int DM_WORDS     = 2,
    parameter int DM_AW        = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              retire,
    input  logic              dump_req,
    output logic              cpu_halt,
    output logic [4:0]        rf_raddr,
    input  logic [WORD_W-1:0] rf_rdata,
    output logic [DM_AW-1:0]  dm_raddr,
    input  logic [WORD_W-1:0] dm_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [WORD_W-1:0] dump_data,
    output logic [TAG_W-1:0]  dump_tag,
    output logic              dump_last,
    output logic              done
);

    localparam logic [TAG_IDX_W-1:0] LAST_MEM    = TAG_IDX_W'(DM_WORDS - 1);
    localparam logic [TAG_IDX_W-1:0] LAST_REG    = TAG_IDX_W'(REG_COUNT - 1);
    localparam logic [31:0]          TRIG_CNT    = 32'(INST_NUM - 1);
    localparam bit                   CNT_TRIG_EN = (INST_NUM != 0);

    logic [1:0]           state;
    logic [31:0]          ret_cnt;
    logic [TAG_IDX_W-1:0] idx;
    logic                 in_dump;
    logic                 load;
    logic                 trigger;
    logic [WORD_W-1:0]    rd_data;
    logic [TAG_W-1:0]     rd_tag;
    logic                 rd_last;

    assign in_dump  = (state == ST_REGS) || (state == ST_MEM);
    assign load     = in_dump && (!dump_valid || dump_ready);
    // Both triggers can coincide; they share one RUN->REGS transition, so only one dump starts.
    assign trigger  = (state == ST_RUN) &&
                      (dump_req || (CNT_TRIG_EN && retire && (ret_cnt == TRIG_CNT)));
    assign rf_raddr = idx[4:0];
    assign dm_raddr = DM_AW'(DM_BASE_WORD) + DM_AW'(idx);

    always_comb begin
        rd_data = dm_rdata;
        rd_tag  = mem_tag(idx);
        rd_last = (idx == LAST_MEM);
        if (state == ST_REGS) begin
            // r0 is hardwired zero in the CPU even if its storage holds junk.
            rd_data = (idx == '0) ? '0 : rf_rdata;
            rd_tag  = reg_tag(idx[4:0]);
            rd_last = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_RUN;
            ret_cnt  <= '0;
            idx      <= '0;
            cpu_halt <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (retire && (ret_cnt != '1))
                        ret_cnt <= ret_cnt + 32'd1;
                    if (trigger) begin
                        state    <= ST_REGS;
                        cpu_halt <= 1'b1;
                        idx      <= '0;
                    end
                end
                ST_REGS: begin
                    if (load) begin
                        if (idx == LAST_REG) begin
                            idx   <= '0;
                            state <= ST_MEM;
                        end else begin
                            idx <= idx + TAG_IDX_W'(1);
                        end
                    end
                end
                ST_MEM: begin
                    if (load) begin
                        if (idx == LAST_MEM)
                            state <= ST_DONE;
                        else
                            idx <= idx + TAG_IDX_W'(1);
                    end
                end
                default: begin
                    if (dump_valid && dump_ready)
                        done <= 1'b1;
                end
            endcase
        end
    end

    dump_out_reg u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .ready     (dump_ready),
        .load_data (rd_data),
        .load_tag  (rd_tag),
        .load_last (rd_last),
        .valid     (dump_valid),
        .data      (dump_data),
        .tag       (dump_tag),
        .last      (dump_last)
    );

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Randomized bench for cpu_state_dumper with a transaction-level model of the dump.
module tb_cpu_state_dumper;

    localparam int INST_NUM = 35;
    localparam int DM_BASE  = 20;
    localparam int DM_WORDS = 2;
    localparam int DM_AW    = 10;
    localparam int N_WORDS  = 32 + DM_WORDS;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              retire = 1'b0;
    logic              dump_req = 1'b0;
    logic              dump_ready = 1'b0;
    logic              cpu_halt;
    logic [4:0]        rf_raddr;
    logic [31:0]       rf_rdata;
    logic [DM_AW-1:0]  dm_raddr;
    logic [31:0]       dm_rdata;
    logic              dump_valid;
    logic [31:0]       dump_data;
    logic [7:0]        dump_tag;
    logic              dump_last;
    logic              done;

    logic [31:0] rf [32];
    logic [31:0] dm [1 << DM_AW];

    assign rf_rdata = rf[rf_raddr];
    assign dm_rdata = dm[dm_raddr];

    always #5 clk = ~clk;

    cpu_state_dumper #(
        .INST_NUM     (INST_NUM),
        .DM_BASE_WORD (DM_BASE),
        .DM_WORDS     (DM_WORDS),
        .DM_AW        (DM_AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .retire     (retire),
        .dump_req   (dump_req),
        .cpu_halt   (cpu_halt),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .dm_raddr   (dm_raddr),
        .dm_rdata   (dm_rdata),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .dump_tag   (dump_tag),
        .dump_last  (dump_last),
        .done       (done)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input int i);
        if (i == 0) return 32'd0;
        if (i < 32) return rf[5'(i)];
        return dm[10'(DM_BASE + i - 32)];
    endfunction

    function automatic logic [31:0] exp_tag(input int i);
        if (i < 32) return 32'(i);
        return 32'h80 | 32'(i - 32);
    endfunction

    // Model state: what the dump must look like, tracked per transaction.
    bit          m_halted;
    bit          m_done;
    int          m_ret;
    int          m_age;
    int          m_acc;
    int          m_cyc;
    int          m_halt_ret;
    int          m_halt_cyc;
    int          m_done_cyc;
    bit          cpu_wr;
    logic [31:0] rx     [N_WORDS];
    logic [31:0] ref_rx [N_WORDS];

    bit          p_stall;
    logic [31:0] p_data;
    logic [7:0]  p_tag;
    logic        p_last;

    always @(posedge clk) begin
        bit         hs;
        logic [4:0] k;
        if (!rst) begin
            m_halted = 0; m_done = 0; m_ret = 0; m_age = 0; m_acc = 0; m_cyc = 0;
            m_halt_ret = -1; m_halt_cyc = -1; m_done_cyc = -1;
            p_stall = 0;
        end else begin
            m_cyc++;
            hs = dump_valid && dump_ready;
            if (hs && m_acc < N_WORDS) begin
                check("hs_data", dump_data, exp_data(m_acc));
                check("hs_tag", {24'd0, dump_tag}, exp_tag(m_acc));
                check("hs_last", {31'd0, dump_last}, {31'd0, m_acc == N_WORDS - 1});
                rx[m_acc] = dump_data;
            end
            if (hs) begin
                m_acc++;
                if (m_acc == N_WORDS) begin
                    m_done     = 1;
                    m_done_cyc = m_cyc;
                end
            end
            if (m_halted) begin
                m_age++;
            end else begin
                if (retire) m_ret++;
                if (dump_req || (retire && m_ret == INST_NUM)) begin
                    m_halted   = 1;
                    m_age      = 0;
                    m_halt_ret = m_ret;
                    m_halt_cyc = m_cyc;
                end
            end
            // The CPU itself: a retiring, unhalted instruction may update state.
            if (!cpu_halt && retire && cpu_wr) begin
                k = 5'($urandom_range(30, 1));
                rf[k] = $urandom;
                dm[10'(DM_BASE + $urandom_range(DM_WORDS - 1, 0))] = $urandom;
            end
            p_stall = dump_valid && !dump_ready;
            p_data  = dump_data;
            p_tag   = dump_tag;
            p_last  = dump_last;
        end
        #1;
        check("cpu_halt", {31'd0, cpu_halt}, {31'd0, m_halted});
        check("done", {31'd0, done}, {31'd0, m_done});
        check("dump_valid", {31'd0, dump_valid},
              {31'd0, m_halted && m_age >= 1 && m_acc < N_WORDS});
        if (p_stall) begin
            check("stall_data", dump_data, p_data);
            check("stall_tag", {24'd0, dump_tag}, {24'd0, p_tag});
            check("stall_last", {31'd0, dump_last}, {31'd0, p_last});
        end
        if (!rst) begin
            check("rst_data", dump_data, 32'd0);
            check("rst_tag", {24'd0, dump_tag}, 32'd0);
            check("rst_last", {31'd0, dump_last}, 32'd0);
        end
    end

    logic pat [4];

    task automatic check_reset_outputs(input string tag);
        check({tag, "_halt"}, {31'd0, cpu_halt}, 32'd0);
        check({tag, "_valid"}, {31'd0, dump_valid}, 32'd0);
        check({tag, "_data"}, dump_data, 32'd0);
        check({tag, "_tag"}, {24'd0, dump_tag}, 32'd0);
        check({tag, "_last"}, {31'd0, dump_last}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_rf_raddr"}, {27'd0, rf_raddr}, 32'd0);
        check({tag, "_dm_raddr"}, {22'd0, dm_raddr}, 32'd20);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; retire = 1'b0; dump_req = 1'b0; dump_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // rmode: 0 ready always, 1 ready pattern 1,0,0,1, 2 random ready.
    task automatic run(input int rmode, input bit wr, input int req_cyc, input bit rnd,
                       input int abort_at);
        bit finished;
        finished = 0;
        cpu_wr   = wr;
        rst      = 1'b1;
        for (int c = 1; c <= 800; c++) begin
            retire     = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            dump_req   = (c == req_cyc) || (rnd && $urandom_range(39, 0) == 0);
            dump_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? pat[(c - 1) % 4]
                                             : 1'($urandom_range(1, 0));
            @(negedge clk);
            if (abort_at > 0 && m_acc >= abort_at) begin finished = 1; break; end
            if (abort_at == 0 && m_done) begin finished = 1; break; end
        end
        check("run_completed", {31'd0, finished}, 32'd1);
        if (abort_at == 0) begin
            for (int c = 0; c < 12; c++) begin
                retire     = 1'b1;
                dump_req   = c[0];
                dump_ready = 1'($urandom_range(1, 0));
                @(negedge clk);
            end
        end
        dump_req = 1'b0;
    endtask

    initial begin
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
        for (int i = 0; i < (1 << DM_AW); i++) dm[i] = 32'(i * 3);
        rf[0]  = 32'hDEADBEEF;
        rf[31] = 32'h12345678;
        dm[20] = 32'd5;
        dm[21] = 32'hA5A5_0021;

        do_reset();
        check_reset_outputs("reset");

        // Plain run: retire every cycle, ready always high.
        run(0, 1'b0, 0, 1'b0, 0);
        check("run1_halt_retires", 32'(m_halt_ret), 32'd35);
        check("run1_halt_cycle", 32'(m_halt_cyc), 32'd35);
        check("run1_done_cycle", 32'(m_done_cyc), 32'd70);
        check("run1_r0", rx[0], 32'd0);
        check("run1_r31", rx[31], 32'h12345678);
        check("run1_mem0", rx[32], 32'd5);
        check("run1_mem1", rx[33], 32'hA5A5_0021);
        for (int i = 0; i < N_WORDS; i++) ref_rx[i] = rx[i];

        // Same state, stalling sink: identical word sequence.
        do_reset();
        run(1, 1'b0, 0, 1'b0, 0);
        check("run2_halt_retires", 32'(m_halt_ret), 32'd35);
        for (int i = 0; i < N_WORDS; i++) check("run2_seq", rx[i], ref_rx[i]);

        // Early dump request at cycle 10; later triggers must be ignored.
        do_reset();
        run(2, 1'b1, 10, 1'b0, 0);
        check("run3_halt_retires", 32'(m_halt_ret), 32'd10);
        check("run3_words", 32'(m_acc), 32'(N_WORDS));

        // Request coinciding with the 35th retire.
        do_reset();
        run(0, 1'b1, 35, 1'b0, 0);
        check("run4_halt_retires", 32'(m_halt_ret), 32'd35);
        check("run4_words", 32'(m_acc), 32'(N_WORDS));

        // Abort mid-dump with an asynchronous reset, then a full dump again.
        do_reset();
        run(0, 1'b1, 0, 1'b0, 12);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async");
        repeat (2) @(negedge clk);
        run(2, 1'b1, 0, 1'b0, 0);
        check("run5_halt_retires", 32'(m_halt_ret), 32'd35);

        // Random retire, ready and request traffic.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            run(2, 1'b1, 0, 1'b1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
